// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache read-path slice: the address field widths
// (byte offset, set, way, tag), a helper that splits a byte address into
// tag and set, and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  // Default geometry; modules derive their own widths from their parameters
  // through the functions below so that non-default instances stay consistent.
  localparam int DefaultAddrSize  = 32;
  localparam int DefaultNumSets   = 16;
  localparam int DefaultNumWays   = 4;
  localparam int DefaultBlockSize = 32;

  function automatic int byte_offset_size(input int block_size);
    return $clog2(block_size / 4);
  endfunction

  function automatic int set_size(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int way_size(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int tag_size(input int addr_size, input int num_sets,
                                  input int block_size);
    return addr_size - set_size(num_sets) - byte_offset_size(block_size);
  endfunction

  localparam int ByteOffsetSize = byte_offset_size(DefaultBlockSize);
  localparam int SetSize        = set_size(DefaultNumSets);
  localparam int WaySize        = way_size(DefaultNumWays);
  localparam int TagSize        = tag_size(DefaultAddrSize, DefaultNumSets,
                                           DefaultBlockSize);

  // Fields are returned at full 64-bit width; callers size-cast them down to
  // their own TagSize/SetSize.
  typedef struct packed {
    logic [63:0] tag;
    logic [63:0] set;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [63:0] addr,
                                             input int offset_bits,
                                             input int set_bits);
    addr_split_t s;
    s.set = (addr >> offset_bits) & ((64'd1 << set_bits) - 64'd1);
    s.tag = addr >> (offset_bits + set_bits);
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS,
    FILL
  } cache_state_e;

endpackage

// File: rtl/cache_replacement_rr.sv
// -----------------------------------------------------------------------------
// cache_replacement_rr
// Per-set round-robin replacement state. The victim is the lowest-index
// invalid way when one exists, otherwise the set's round-robin pointer.
// The pointer only moves when the owner pulses advance for a victim that
// actually came from the pointer.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers -> 0)
//   set_idx         set being looked up / advanced
//   valid_flags     per-way valid bits of that set
//   advance         increment rr_ptr[set_idx] modulo NUM_WAYS
//   victim_way      selected victim (combinational)
//   victim_from_rr  1 when victim_way came from the round-robin pointer
// -----------------------------------------------------------------------------
module cache_replacement_rr
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  localparam int SetBits = set_size(NUM_SETS),
  localparam int WayBits = way_size(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SetBits-1:0] set_idx,
  input  logic [NUM_WAYS-1:0] valid_flags,
  input  logic               advance,
  output logic [WayBits-1:0] victim_way,
  output logic               victim_from_rr
);

  logic [WayBits-1:0] rr_ptr [NUM_SETS];

  // Pointer array; NUM_WAYS is a power of two so the natural wrap of the
  // WayBits-wide add gives the modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else if (advance) begin
      rr_ptr[set_idx] <= rr_ptr[set_idx] + WayBits'(1);
    end
  end

  // Scan from the top down so the lowest-index invalid way wins.
  always_comb begin
    victim_way     = rr_ptr[set_idx];
    victim_from_rr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_flags[w]) begin
        victim_way     = WayBits'(w);
        victim_from_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Read-path controller for one cache_memory array. A CPU read is latched,
// looked up in the array for one cycle, and either answered from the array
// (hit) or fetched from main memory over a req/ack handshake and written into
// a victim way while the same data is returned to the CPU (miss).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req_valid/ready/addr         CPU read request (accepted in IDLE)
//   cpu_resp_valid/data              one-cycle response pulse + block
//   mem_req/mem_addr                 block read request, aligned address
//   mem_ack/mem_read_data            one-cycle ack pulse + fetched block
//   cm_way/cm_set/cm_tag             cache_memory select and tag
//   cm_write_enable/cm_write_data    cache_memory fill strobe and data
//   cm_read_data/cm_hits/cm_valid_flags  cache_memory lookup results
// -----------------------------------------------------------------------------
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int BLOCK_SIZE = 32,
  localparam int OffsetBits = byte_offset_size(BLOCK_SIZE),
  localparam int SetBits    = set_size(NUM_SETS),
  localparam int WayBits    = way_size(NUM_WAYS),
  localparam int TagBits    = tag_size(ADDR_SIZE, NUM_SETS, BLOCK_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_SIZE-1:0]  cpu_req_addr,
  output logic                  cpu_resp_valid,
  output logic [BLOCK_SIZE-1:0] cpu_resp_data,
  output logic                  mem_req,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic [BLOCK_SIZE-1:0] mem_read_data,
  output logic [WayBits-1:0]    cm_way,
  output logic [SetBits-1:0]    cm_set,
  output logic [TagBits-1:0]    cm_tag,
  output logic                  cm_write_enable,
  output logic [BLOCK_SIZE-1:0] cm_write_data,
  input  logic [BLOCK_SIZE-1:0] cm_read_data,
  input  logic [NUM_WAYS-1:0]   cm_hits,
  input  logic [NUM_WAYS-1:0]   cm_valid_flags
);

  localparam logic [ADDR_SIZE-1:0] OffsetMask =
    ADDR_SIZE'((64'd1 << OffsetBits) - 64'd1);

  cache_state_e          state;
  logic [ADDR_SIZE-1:0]  req_addr;
  logic [WayBits-1:0]    victim_way_q;
  logic                  victim_rr_q;
  logic [BLOCK_SIZE-1:0] fill_buf;

  logic [ADDR_SIZE-1:0]  lookup_addr;
  addr_split_t           lookup_split;
  logic                  hit_any;
  logic [WayBits-1:0]    hit_way;
  logic [WayBits-1:0]    repl_victim;
  logic                  repl_from_rr;
  logic                  repl_advance;

  // In IDLE the array sees the incoming address (nothing depends on it);
  // everywhere else it sees the latched request so set/tag stay stable.
  always_comb begin
    lookup_addr  = (state == IDLE) ? cpu_req_addr : req_addr;
    lookup_split = split_addr(64'(lookup_addr), OffsetBits, SetBits);
    cm_set       = SetBits'(lookup_split.set);
    cm_tag       = TagBits'(lookup_split.tag);
  end

  // Multiple hits are illegal; scanning downwards makes the lowest index win.
  always_comb begin
    hit_any = |cm_hits;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (cm_hits[w]) begin
        hit_way = WayBits'(w);
      end
    end
  end

  assign repl_advance = (state == FILL) && victim_rr_q;

  cache_replacement_rr #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_repl (
    .clk            (clk),
    .rst            (rst),
    .set_idx        (cm_set),
    .valid_flags    (cm_valid_flags),
    .advance        (repl_advance),
    .victim_way     (repl_victim),
    .victim_from_rr (repl_from_rr)
  );

  // Way select, write data and the CPU response. The hit response has to be
  // combinational because cm_hits and cm_read_data only exist in LOOKUP.
  always_comb begin
    cm_way         = '0;
    cm_write_data  = fill_buf;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    case (state)
      LOOKUP: begin
        cm_way = hit_way;
        if (hit_any) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = cm_read_data;
        end
      end
      FILL: begin
        cm_way         = victim_way_q;
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = fill_buf;
      end
      default: begin
        cm_way = '0;
      end
    endcase
  end

  // Main FSM with registered ready/mem_req/mem_addr/write strobe. A reset in
  // MISS simply returns to IDLE; a later mem_ack is ignored outside MISS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_addr        <= '0;
      victim_way_q    <= '0;
      victim_rr_q     <= 1'b0;
      fill_buf        <= '0;
      cpu_req_ready   <= 1'b1;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      cm_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_addr      <= cpu_req_addr;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            cpu_req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            victim_way_q <= repl_victim;
            victim_rr_q  <= repl_from_rr;
            mem_req      <= 1'b1;
            mem_addr     <= req_addr & ~OffsetMask;
            state        <= MISS;
          end
        end
        MISS: begin
          if (mem_ack) begin
            fill_buf        <= mem_read_data;
            mem_req         <= 1'b0;
            cm_write_enable <= 1'b1;
            state           <= FILL;
          end
        end
        FILL: begin
          cm_write_enable <= 1'b0;
          cpu_req_ready   <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          cm_write_enable <= 1'b0;
          mem_req         <= 1'b0;
          cpu_req_ready   <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
// Directed bench for cache_controller with default geometry (offset [2:0],
// set [6:3], tag [31:7]). A small behavioural cache array stands in for
// cache_memory; main memory is driven directly by the sequence.
// -----------------------------------------------------------------------------
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_read_data;
  logic [1:0]  cm_way;
  logic [3:0]  cm_set;
  logic [24:0] cm_tag;
  logic        cm_write_enable;
  logic [31:0] cm_write_data;
  logic [31:0] cm_read_data;
  logic [3:0]  cm_hits;
  logic [3:0]  cm_valid_flags;

  int tests_run    = 0;
  int tests_failed = 0;

  cache_controller #(
    .ADDR_SIZE  (32),
    .NUM_SETS   (16),
    .NUM_WAYS   (4),
    .BLOCK_SIZE (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_data   (cpu_resp_data),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_read_data   (mem_read_data),
    .cm_way          (cm_way),
    .cm_set          (cm_set),
    .cm_tag          (cm_tag),
    .cm_write_enable (cm_write_enable),
    .cm_write_data   (cm_write_data),
    .cm_read_data    (cm_read_data),
    .cm_hits         (cm_hits),
    .cm_valid_flags  (cm_valid_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for cache_memory: combinational hits/read data,
  // fill on the clock edge while the strobe is high.
  logic        m_valid [4][16];
  logic [24:0] m_tag   [4][16];
  logic [31:0] m_data  [4][16];
  logic        model_clear;

  always @(posedge clk) begin
    if (model_clear) begin
      for (int w = 0; w < 4; w++) begin
        for (int s = 0; s < 16; s++) begin
          m_valid[w][s] <= 1'b0;
          m_tag[w][s]   <= '0;
          m_data[w][s]  <= '0;
        end
      end
    end else if (cm_write_enable) begin
      m_valid[cm_way][cm_set] <= 1'b1;
      m_tag[cm_way][cm_set]   <= cm_tag;
      m_data[cm_way][cm_set]  <= cm_write_data;
    end
  end

  always_comb begin
    cm_hits        = '0;
    cm_valid_flags = '0;
    for (int w = 0; w < 4; w++) begin
      cm_valid_flags[w] = m_valid[w][cm_set];
      cm_hits[w]        = m_valid[w][cm_set] && (m_tag[w][cm_set] == cm_tag);
    end
    cm_read_data = m_data[cm_way][cm_set];
  end

  task automatic applyStimulus(input logic v, input logic [31:0] a);
    cpu_req_valid = v;
    cpu_req_addr  = a;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Full miss: accept, LOOKUP miss, MISS for 'delay' sampled cycles, ack,
  // then FILL. Entered and left on a falling edge.
  task automatic readMiss(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_mem_addr, input logic [3:0] exp_set,
                          input logic [24:0] exp_tag, input logic [1:0] exp_way,
                          input logic [31:0] data, input int delay);
    applyStimulus(1'b1, addr);
    @(negedge clk);
    applyStimulus(1'b0, addr);
    checkOutput({tag, "_lookup_resp"}, 64'(cpu_resp_valid), 64'd0);
    checkOutput({tag, "_lookup_ready"}, 64'(cpu_req_ready), 64'd0);
    @(negedge clk);
    for (int i = 0; i < delay; i++) begin
      checkOutput({tag, "_mem_req"}, 64'(mem_req), 64'd1);
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_mem_addr));
      checkOutput({tag, "_miss_we"}, 64'(cm_write_enable), 64'd0);
      if (i != delay - 1) @(negedge clk);
    end
    mem_ack       = 1'b1;
    mem_read_data = data;
    @(negedge clk);
    mem_ack       = 1'b0;
    mem_read_data = '0;
    checkOutput({tag, "_fill_we"}, 64'(cm_write_enable), 64'd1);
    checkOutput({tag, "_fill_way"}, 64'(cm_way), 64'(exp_way));
    checkOutput({tag, "_fill_set"}, 64'(cm_set), 64'(exp_set));
    checkOutput({tag, "_fill_tag"}, 64'(cm_tag), 64'(exp_tag));
    checkOutput({tag, "_fill_wdata"}, 64'(cm_write_data), 64'(data));
    checkOutput({tag, "_fill_resp"}, 64'(cpu_resp_valid), 64'd1);
    checkOutput({tag, "_fill_rdata"}, 64'(cpu_resp_data), 64'(data));
    checkOutput({tag, "_fill_mem_req"}, 64'(mem_req), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_done_we"}, 64'(cm_write_enable), 64'd0);
    checkOutput({tag, "_done_resp"}, 64'(cpu_resp_valid), 64'd0);
    checkOutput({tag, "_done_ready"}, 64'(cpu_req_ready), 64'd1);
  endtask

  task automatic readHit(input string tag, input logic [31:0] addr,
                         input logic [1:0] exp_way, input logic [31:0] data);
    applyStimulus(1'b1, addr);
    @(negedge clk);
    applyStimulus(1'b0, addr);
    checkOutput({tag, "_resp"}, 64'(cpu_resp_valid), 64'd1);
    checkOutput({tag, "_rdata"}, 64'(cpu_resp_data), 64'(data));
    checkOutput({tag, "_way"}, 64'(cm_way), 64'(exp_way));
    checkOutput({tag, "_ready"}, 64'(cpu_req_ready), 64'd0);
    checkOutput({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_after_resp"}, 64'(cpu_resp_valid), 64'd0);
    checkOutput({tag, "_after_ready"}, 64'(cpu_req_ready), 64'd1);
    checkOutput({tag, "_after_mem_req"}, 64'(mem_req), 64'd0);
  endtask

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_clear   = 1'b1;
    rst           = 1'b1;
    mem_ack       = 1'b0;
    mem_read_data = '0;
    applyStimulus(1'b0, 32'h0);
    repeat (3) @(negedge clk);
    model_clear = 1'b0;
    rst         = 1'b0;

    checkOutput("reset_ready", 64'(cpu_req_ready), 64'd1);
    checkOutput("reset_resp", 64'(cpu_resp_valid), 64'd0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset_we", 64'(cm_write_enable), 64'd0);

    // Cold miss then hit on the same block.
    readMiss("cold_0x10", 32'h10, 32'h10, 4'd2, 25'd0, 2'd0, 32'hDEADBEEF, 3);
    readHit("hit_0x10", 32'h10, 2'd0, 32'hDEADBEEF);

    // Fill the remaining ways of set 2 through invalid-way selection.
    readMiss("fill_0x90", 32'h90, 32'h90, 4'd2, 25'd1, 2'd1, 32'h11111111, 1);
    readMiss("fill_0x110", 32'h110, 32'h110, 4'd2, 25'd2, 2'd2, 32'h22222222, 2);
    readMiss("fill_0x190", 32'h190, 32'h190, 4'd2, 25'd3, 2'd3, 32'h33333333, 1);

    // Set full: round-robin pointer starts at 0, then moves to 1.
    readMiss("evict_0x210", 32'h210, 32'h210, 4'd2, 25'd4, 2'd0, 32'h44444444, 2);
    readHit("hit_0x90", 32'h90, 2'd1, 32'h11111111);
    readMiss("evict_0x10", 32'h10, 32'h10, 4'd2, 25'd0, 2'd1, 32'h55555555, 1);

    // Reset while the fetch is outstanding, then a stray ack.
    applyStimulus(1'b1, 32'h310);
    @(negedge clk);
    applyStimulus(1'b0, 32'h310);
    @(negedge clk);
    checkOutput("rstmiss_mem_req_before", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmiss_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rstmiss_ready", 64'(cpu_req_ready), 64'd1);
    checkOutput("rstmiss_resp", 64'(cpu_resp_valid), 64'd0);
    mem_ack       = 1'b1;
    mem_read_data = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack       = 1'b0;
    mem_read_data = '0;
    checkOutput("late_ack_we", 64'(cm_write_enable), 64'd0);
    checkOutput("late_ack_resp", 64'(cpu_resp_valid), 64'd0);
    checkOutput("late_ack_ready", 64'(cpu_req_ready), 64'd1);
    checkOutput("late_ack_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    checkOutput("late_ack_we2", 64'(cm_write_enable), 64'd0);
    checkOutput("late_ack_resp2", 64'(cpu_resp_valid), 64'd0);

    // Long ack stall with a competing request; pointers were reset to 0.
    applyStimulus(1'b1, 32'h390);
    @(negedge clk);
    applyStimulus(1'b0, 32'h390);
    checkOutput("stall_lookup_resp", 64'(cpu_resp_valid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall_mem_req", 64'(mem_req), 64'd1);
      checkOutput("stall_mem_addr", 64'(mem_addr), 64'h390);
      checkOutput("stall_ready", 64'(cpu_req_ready), 64'd0);
      if (i == 4) applyStimulus(1'b1, 32'h18);
      if (i == 18) applyStimulus(1'b0, 32'h18);
      @(negedge clk);
    end
    mem_ack       = 1'b1;
    mem_read_data = 32'h77777777;
    @(negedge clk);
    mem_ack       = 1'b0;
    mem_read_data = '0;
    checkOutput("stall_fill_we", 64'(cm_write_enable), 64'd1);
    checkOutput("stall_fill_way", 64'(cm_way), 64'd0);
    checkOutput("stall_fill_set", 64'(cm_set), 64'd2);
    checkOutput("stall_fill_tag", 64'(cm_tag), 64'd7);
    checkOutput("stall_fill_rdata", 64'(cpu_resp_data), 64'h77777777);
    @(negedge clk);
    checkOutput("stall_done_ready", 64'(cpu_req_ready), 64'd1);
    checkOutput("stall_done_mem_req", 64'(mem_req), 64'd0);
    readHit("hit_0x390", 32'h390, 2'd0, 32'h77777777);
    readMiss("evict_0x410", 32'h410, 32'h410, 4'd2, 25'd8, 2'd1, 32'h88888888, 1);

    // Non-zero offset bits and the top of the address space.
    readMiss("off_0x5c", 32'h5C, 32'h58, 4'd11, 25'd0, 2'd0, 32'hA5A5A5A5, 2);
    readHit("hit_0x5f", 32'h5F, 2'd0, 32'hA5A5A5A5);
    readMiss("top_addr", 32'hFFFFFFFF, 32'hFFFFFFF8, 4'd15, 25'h1FFFFFF, 2'd0,
             32'hCAFEF00D, 1);
    readHit("hit_top", 32'hFFFFFFF8, 2'd0, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
